// File: rtl/sync_fifo_ctl.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_ctl
// Description : Single-clock FIFO with parametrised width/depth, standard or
//               first-word-fall-through read mode, occupancy count,
//               programmable almost-full/almost-empty thresholds, sticky
//               overflow/underflow flags and a synchronous flush.
// Ports       : clk, rst (async, active-high)
//               flush          - synchronous clear of pointers, count, errors
//               wr_en, data_in - push request and data
//               rd_en          - pop request (FWFT: acknowledges shown word)
//               data_out       - read data
//               full, empty, almost_full, almost_empty, count - status
//               overflow, underflow - sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_ctl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] C_AF    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] C_AE    = (ADDR_WIDTH+1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q,  count_d;
    logic                  ovf_q,    ovf_d;
    logic                  unf_q,    unf_d;

    logic rd_acc;
    logic wr_acc;

    // Status decoded purely from the count register so request inputs never
    // reach the flags combinationally.
    assign full         = (count_q == C_DEPTH);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= C_AF);
    assign almost_empty = (count_q <= C_AE);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // A write while full is still accepted when a read frees the slot in the
    // same cycle. Flush overrides both requests.
    assign rd_acc = rd_en & ~empty & ~flush;
    assign wr_acc = wr_en & (~full | rd_acc) & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (wr_en & full & ~rd_acc) ovf_d = 1'b1;
            if (rd_en & empty)          unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is deliberately not reset; stale words are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = empty ? '0 : mem_q[rd_ptr_q];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q, dout_d;

            always_comb begin
                dout_d = dout_q;
                if (flush)       dout_d = '0;
                else if (rd_acc) dout_d = mem_q[rd_ptr_q];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) dout_q <= '0;
                else     dout_q <= dout_d;
            end

            assign data_out = dout_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_ctl
// Description : Self-checking bench for sync_fifo_ctl. Two instances share the
//               same stimulus: a standard-mode FIFO with thresholds 12/3 and a
//               FWFT FIFO with default thresholds 14/2. A queue-based model
//               predicts contents, flags and read data for both.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_ctl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          wr_en;
    logic [DW-1:0] data_in;
    logic          rd_en;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [AW:0]   s_cnt, f_cnt;

    sync_fifo_ctl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0),
                    .AF_LEVEL(12), .AE_LEVEL(3)) u_std (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(s_dout), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_cnt),
        .overflow(s_ovf), .underflow(s_unf));

    sync_fifo_ctl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(f_dout), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_cnt),
        .overflow(f_ovf), .underflow(f_unf));

    always #5 clk = ~clk;

    // Reference model
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_std_dout;
    bit            m_ovf, m_unf;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = m_q.size();
        check("s_count", 32'(s_cnt), 32'(n));
        check("s_full",  32'(s_full),  32'(n == DEPTH));
        check("s_empty", 32'(s_empty), 32'(n == 0));
        check("s_af",    32'(s_af),    32'(n >= 12));
        check("s_ae",    32'(s_ae),    32'(n <= 3));
        check("s_ovf",   32'(s_ovf),   32'(m_ovf));
        check("s_unf",   32'(s_unf),   32'(m_unf));
        check("s_dout",  32'(s_dout),  32'(m_std_dout));
        check("f_count", 32'(f_cnt), 32'(n));
        check("f_full",  32'(f_full),  32'(n == DEPTH));
        check("f_empty", 32'(f_empty), 32'(n == 0));
        check("f_af",    32'(f_af),    32'(n >= 14));
        check("f_ae",    32'(f_ae),    32'(n <= 2));
        check("f_ovf",   32'(f_ovf),   32'(m_ovf));
        check("f_unf",   32'(f_unf),   32'(m_unf));
        check("f_dout",  32'(f_dout),  32'((n == 0) ? 0 : m_q[0]));
    endtask

    task automatic model_reset();
        m_q.delete();
        m_std_dout = '0;
        m_ovf = 0;
        m_unf = 0;
    endtask

    // One clock: present inputs, take the edge, update the model, compare.
    task automatic step(input bit w, input bit r, input logic [DW-1:0] d, input bit fl);
        bit ra, wa;
        wr_en = w; rd_en = r; data_in = d; flush = fl;
        @(posedge clk);
        #1;
        if (fl) begin
            m_q.delete();
            m_std_dout = '0;
            m_ovf = 0;
            m_unf = 0;
        end else begin
            ra = r && (m_q.size() > 0);
            wa = w && ((m_q.size() < DEPTH) || ra);
            if (r && m_q.size() == 0)               m_unf = 1;
            if (w && m_q.size() == DEPTH && !ra)    m_ovf = 1;
            if (ra) m_std_dout = m_q.pop_front();
            if (wa) m_q.push_back(d);
        end
        wr_en = 0; rd_en = 0; flush = 0;
        check_all();
    endtask

    int bias, pw, pr;

    initial begin
        rst = 1; flush = 0; wr_en = 0; rd_en = 0; data_in = '0;
        model_reset();
        #1;
        check_all();
        @(posedge clk); #1;
        rst = 0;
        check_all();

        // Fill with 0x01..0x10, then one write too many
        for (int i = 1; i <= 16; i++) step(1, 0, DW'(i), 0);
        step(1, 0, 8'hEE, 0);
        // Drain: standard data_out follows one cycle after each pop
        for (int i = 0; i < 16; i++) step(0, 1, 8'h00, 0);

        // Wrap-around with clean error flags
        @(posedge clk); #1;
        rst = 1; #1; model_reset(); check_all();
        @(posedge clk); #1; rst = 0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 10; i++) step(1, 0, DW'(8'h40 + k*16 + i), 0);
            for (int i = 0; i < 10; i++) step(0, 1, 8'h00, 0);
        end

        // Simultaneous push/pop at full and at empty
        for (int i = 0; i < 16; i++) step(1, 0, DW'(8'h80 + i), 0);
        step(1, 1, 8'hAA, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 8'h00, 0);
        step(1, 1, 8'h55, 0);
        step(0, 1, 8'h00, 0);

        // FWFT visibility without rd_en, then pop
        step(1, 0, 8'h3C, 0);
        step(0, 0, 8'h00, 0);
        step(0, 1, 8'h00, 0);

        // Threshold sweep 0..16..0
        for (int i = 0; i < 17; i++) step(1, 0, DW'($urandom), 0);
        for (int i = 0; i < 17; i++) step(0, 1, 8'h00, 0);

        // Flush at count 9 with overflow set: write that cycle is ignored
        for (int i = 0; i < 17; i++) step(1, 0, DW'(i), 0);
        for (int i = 0; i < 7; i++)  step(0, 1, 8'h00, 0);
        step(1, 0, 8'h99, 1);
        step(0, 0, 8'h00, 0);

        // Randomised traffic with phases biased toward full, empty, balanced
        for (int i = 0; i < 1500; i++) begin
            bias = (i / 200) % 3;
            pw = (bias == 0) ? 75 : (bias == 1) ? 25 : 50;
            pr = 100 - pw;
            step($urandom_range(99) < pw, $urandom_range(99) < pr,
                 DW'($urandom), $urandom_range(149) == 0);
        end

        // Asynchronous reset mid-burst, away from the clock edge
        for (int i = 0; i < 6; i++) step(1, i[0], DW'($urandom), 0);
        #3;
        rst = 1;
        #1;
        model_reset();
        check_all();
        @(posedge clk); #1;
        check_all();
        rst = 0;
        for (int i = 0; i < 200; i++)
            step($urandom_range(1), $urandom_range(1), DW'($urandom), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_fifo_ctl.md
# sync_fifo_ctl

Parametrised single-clock FIFO with configurable width and depth, selectable standard or first-word-fall-through (FWFT) read mode, occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. It sits between producer and consumer blocks in the same clock domain and is the general-purpose buffer for new datapaths.

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 4, pointer width; DEPTH = 2**ADDR_WIDTH entries, all usable
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (legal 1..DEPTH)
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (legal 0..DEPTH-1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous clear of contents and error flags
- wr_en  in  1  write request
- data_in  in  DATA_WIDTH  write data
- rd_en  in  1  read (pop) request
- data_out  out  DATA_WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  ADDR_WIDTH+1  words currently stored
- overflow  out  1  sticky: write dropped while full
- underflow  out  1  sticky: read requested while empty

## Operation
- Storage: DEPTH x DATA_WIDTH register array, asynchronous read at rd_ptr. wr_ptr, rd_ptr are ADDR_WIDTH bits and wrap naturally DEPTH-1 -> 0.
- Accepted write: wr_acc = wr_en & (!full | rd_acc). Stores data_in at mem[wr_ptr], wr_ptr+1.
- Accepted read: rd_acc = rd_en & !empty. rd_ptr+1.
- count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither. Never exceeds DEPTH or goes below 0.
- Full with wr_en & rd_en: both accepted, count stays DEPTH.
- Empty with wr_en & rd_en: write accepted, read rejected, underflow set, count -> 1.
- overflow set on wr_en & full & !rd_acc; underflow set on rd_en & empty. Both stay set until flush or rst.
- Standard mode (FWFT=0): data_out register loads mem[rd_ptr] on rd_acc, otherwise holds.
- FWFT mode (FWFT=1): data_out = empty ? 0 : mem[rd_ptr] combinationally; rd_en acknowledges/pops the word shown.
- flush: has priority over wr_en/rd_en that cycle; pointers and count -> 0, overflow/underflow -> 0, standard-mode data_out -> 0; memory contents not cleared.
- full, empty, almost_full, almost_empty decoded combinationally from the count register (no glitch paths from wr_en/rd_en).

## Timing
- Reset values: count 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0, data_out 0, pointers 0.
- rst mid-operation: all of the above immediately, contents discarded.
- Write-to-flag latency: status flags and count reflect an edge's write/read from that edge onward (1 cycle after request presented).
- Standard read latency: data_out valid the edge after rd_acc (1 cycle).
- FWFT latency: word written into empty FIFO at edge N appears on data_out after edge N, same time empty falls.
- Error flags assert at the edge following the offending request.

## Test plan
- Reset then FWFT=0, ADDR_WIDTH=4: write 0x01..0x10 -> full=1, count=16, almost_full=1 after 14th write; 17th write -> overflow=1, count stays 16; read 16 -> data_out 0x01..0x10 each one cycle after rd_en, empty=1.
- Wrap: write 10, read 10, write 10, read 10 (pointers cross 15->0) -> data order preserved, count returns 0, no error flags.
- Simultaneous: at full, wr_en&rd_en with 0xAA -> count stays 16, 0xAA read last; at empty, wr_en&rd_en with 0x55 -> count 1, underflow=1, next read returns 0x55.
- FWFT=1: write 0x3C into empty -> data_out=0x3C and empty=0 next cycle without rd_en; rd_en -> data_out 0, empty=1.
- Thresholds AF_LEVEL=12, AE_LEVEL=3: sweep count 0..16..0 -> almost_empty exactly when count<=3, almost_full exactly when count>=12.
- flush with wr_en=1 at count 9 plus overflow set -> count 0, empty=1, overflow=0, write ignored; async rst mid-burst -> all outputs at reset values immediately.
